// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with write-back port and issue-side RAW hazard scoreboard
//
// Ports:
//   clk, rst_n                      clock (posedge) and asynchronous active-low reset
//   rs1_sel_in/rs2_sel_in           read selects; rs1_data_out/rs2_data_out combinational read data
//   issue_valid_in/issue_we_in      decode presents an instruction / it writes issue_rd_sel_in
//   issue_rd_sel_in                 destination of the presented instruction
//   stall_out                       hold decode; the presented issue is not accepted
//   wb_write_en_in/wb_rd_sel_in/wb_data_in   write-back port from the execute pipeline register
//   pending_out                     per-register "writers in flight" flags
//   underflow_out                   sticky: a write-back arrived for a register with no writer in flight
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int SEL_W    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    rs1_sel_in,
    input  logic [SEL_W-1:0]    rs2_sel_in,
    output logic [DATA_W-1:0]   rs1_data_out,
    output logic [DATA_W-1:0]   rs2_data_out,
    input  logic                issue_valid_in,
    input  logic                issue_we_in,
    input  logic [SEL_W-1:0]    issue_rd_sel_in,
    output logic                stall_out,
    input  logic                wb_write_en_in,
    input  logic [SEL_W-1:0]    wb_rd_sel_in,
    input  logic [DATA_W-1:0]   wb_data_in,
    output logic [NUM_REGS-1:0] pending_out,
    output logic                underflow_out
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs     [NUM_REGS];
    logic [1:0]          pend_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                wb_hit;
    logic                full;

    // Register 0 and out-of-range selects are never read, written, counted or stalled on.
    function automatic logic sel_ok(input logic [SEL_W-1:0] s);
        return s != '0 && int'(s) < NUM_REGS;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [SEL_W-1:0] s);
        return s[IDX_W-1:0];
    endfunction

    always_comb begin
        wb_hit = wb_write_en_in && sel_ok(wb_rd_sel_in);
        // The last in-flight writer retiring this cycle is bypassed rather than stalled on.
        full = issue_we_in && sel_ok(issue_rd_sel_in)
            && pend_cnt[idx(issue_rd_sel_in)] == 2'd3
            && !(wb_write_en_in && wb_rd_sel_in == issue_rd_sel_in);
        stall_out = issue_valid_in && (full
            || (sel_ok(rs1_sel_in) && pend_cnt[idx(rs1_sel_in)] != 2'd0
                && !(wb_write_en_in && wb_rd_sel_in == rs1_sel_in && pend_cnt[idx(rs1_sel_in)] == 2'd1))
            || (sel_ok(rs2_sel_in) && pend_cnt[idx(rs2_sel_in)] != 2'd0
                && !(wb_write_en_in && wb_rd_sel_in == rs2_sel_in && pend_cnt[idx(rs2_sel_in)] == 2'd1)));
        rs1_data_out = !sel_ok(rs1_sel_in) ? '0
            : (wb_write_en_in && wb_rd_sel_in == rs1_sel_in) ? wb_data_in : regs[idx(rs1_sel_in)];
        rs2_data_out = !sel_ok(rs2_sel_in) ? '0
            : (wb_write_en_in && wb_rd_sel_in == rs2_sel_in) ? wb_data_in : regs[idx(rs2_sel_in)];
        for (int r = 0; r < NUM_REGS; r++) begin
            inc[r] = issue_valid_in && !stall_out && issue_we_in && sel_ok(issue_rd_sel_in)
                && int'(issue_rd_sel_in) == r;
            dec[r] = wb_hit && int'(wb_rd_sel_in) == r && pend_cnt[r] != 2'd0;
            pending_out[r] = pend_cnt[r] != 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r]     <= '0;
                pend_cnt[r] <= '0;
            end
            underflow_out <= 1'b0;
        end else begin
            if (wb_hit)
                regs[idx(wb_rd_sel_in)] <= wb_data_in;
            // Data is still written; the count simply stays at zero.
            if (wb_hit && pend_cnt[idx(wb_rd_sel_in)] == 2'd0)
                underflow_out <= 1'b1;
            for (int r = 0; r < NUM_REGS; r++)
                if (inc[r] != dec[r])
                    pend_cnt[r] <= inc[r] ? pend_cnt[r] + 2'd1 : pend_cnt[r] - 2'd1;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: scoreboard bench with a queue-and-count reference model for regfile_scoreboard
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  rs1_sel_in = '0, rs2_sel_in = '0, issue_rd_sel_in = '0, wb_rd_sel_in = '0;
    logic [31:0] rs1_data_out, rs2_data_out, wb_data_in = '0;
    logic        issue_valid_in = 1'b0, issue_we_in = 1'b0, wb_write_en_in = 1'b0;
    logic        stall_out, underflow_out;
    logic [31:0] pending_out;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_sel_in(rs1_sel_in), .rs2_sel_in(rs2_sel_in),
        .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
        .issue_valid_in(issue_valid_in), .issue_we_in(issue_we_in),
        .issue_rd_sel_in(issue_rd_sel_in), .stall_out(stall_out),
        .wb_write_en_in(wb_write_en_in), .wb_rd_sel_in(wb_rd_sel_in), .wb_data_in(wb_data_in),
        .pending_out(pending_out), .underflow_out(underflow_out)
    );

    typedef struct {
        logic [31:0] r1, r2, pend;
        logic        st, uf;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] mregs [32];
    int          mcnt  [32];
    bit          muf;

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic bit vld(int s);
        return s > 0 && s < 32;
    endfunction

    // Writers still outstanding on register s once this cycle's write-back has retired.
    function automatic int left(int s, bit we, int ws);
        return mcnt[s] - ((we && ws == s && mcnt[s] > 0) ? 1 : 0);
    endfunction

    function automatic logic [31:0] rdv(int s, bit we, int ws, logic [31:0] wd);
        if (!vld(s)) return 32'h0;
        return (we && ws == s) ? wd : mregs[s];
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            mregs[r] = '0;
            mcnt[r]  = 0;
        end
        muf = 1'b0;
    endfunction

    function automatic int pick();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
    endfunction

    task automatic step(input bit iv, input bit iwe, input int ird, input int r1, input int r2,
                        input bit we, input int ws, input logic [31:0] wd);
        exp_t e;
        bit   st;
        issue_valid_in  = iv;
        issue_we_in     = iwe;
        issue_rd_sel_in = 6'(ird);
        rs1_sel_in      = 6'(r1);
        rs2_sel_in      = 6'(r2);
        wb_write_en_in  = we;
        wb_rd_sel_in    = 6'(ws);
        wb_data_in      = wd;
        st = iv && ((vld(r1) && left(r1, we, ws) > 0) || (vld(r2) && left(r2, we, ws) > 0)
                    || (iwe && vld(ird) && left(ird, we, ws) == 3));
        e.r1 = rdv(r1, we, ws, wd);
        e.r2 = rdv(r2, we, ws, wd);
        e.st = st;
        e.uf = muf;
        for (int r = 0; r < 32; r++) e.pend[r] = mcnt[r] != 0;
        q.push_back(e);
        @(posedge clk);
        if (we && vld(ws)) begin
            if (mcnt[ws] == 0) muf = 1'b1;
            else mcnt[ws]--;
            mregs[ws] = wd;
        end
        if (iv && !st && iwe && vld(ird)) mcnt[ird]++;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("rs1_data", rs1_data_out, e.r1);
            cmp("rs2_data", rs2_data_out, e.r2);
            cmp("stall", 32'(stall_out), 32'(e.st));
            cmp("pending", pending_out, e.pend);
            cmp("underflow", 32'(underflow_out), 32'(e.uf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ws;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_pending", pending_out, 32'h0);
        cmp("reset_underflow", 32'(underflow_out), 32'h0);
        rst_n = 1'b1;

        // T1: write r5, issue to r7, then drop reset mid-cycle
        step(1, 1, 7, 0, 0, 1, 5, 32'hDEAD);
        issue_valid_in = 1'b1; issue_we_in = 1'b1; issue_rd_sel_in = 6'd7;
        rs1_sel_in = 6'd5; wb_write_en_in = 1'b0;
        #1;
        cmp("t1_pre_rs1", rs1_data_out, 32'hDEAD);
        cmp("t1_pre_pend7", 32'(pending_out[7]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        cmp("t1_rs1", rs1_data_out, 32'h0);
        cmp("t1_pending", pending_out, 32'h0);
        cmp("t1_underflow", 32'(underflow_out), 32'h0);
        cmp("t1_stall", 32'(stall_out), 32'h0);
        issue_valid_in = 1'b0; issue_we_in = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // T2: register 0 is inert
        step(1, 1, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);
        cmp("t2_pend0", 32'(pending_out[0]), 32'h0);

        // T3: write-through bypass, then persistence
        step(1, 1, 3, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 3, 0, 1, 3, 32'h1234);
        step(0, 0, 0, 3, 3, 0, 0, 32'h0);
        step(0, 0, 0, 3, 0, 0, 0, 32'h0);

        // T4: RAW stall released by the retiring write-back
        step(1, 1, 4, 0, 0, 0, 0, 32'h0);
        repeat (3) step(1, 0, 0, 0, 4, 0, 0, 32'h0);
        step(1, 0, 0, 0, 4, 1, 4, 32'h55);

        // T5: saturation at three writers
        repeat (3) step(1, 1, 9, 0, 0, 0, 0, 32'h0);
        step(1, 1, 9, 0, 0, 0, 0, 32'h0);
        cmp("t5_pend9", 32'(pending_out[9]), 32'h1);
        step(1, 1, 9, 0, 0, 1, 9, 32'h99);
        step(1, 1, 9, 0, 0, 0, 0, 32'h0);

        // T6: underflow is sticky
        cmp("t6_pre_underflow", 32'(underflow_out), 32'h0);
        step(0, 0, 0, 0, 0, 1, 6, 32'h77);
        cmp("t6_underflow", 32'(underflow_out), 32'h1);
        step(0, 0, 0, 6, 0, 0, 0, 32'h0);

        // Random traffic, write-backs biased towards registers with writers in flight
        for (int i = 0; i < 1500; i++) begin
            ws = pick();
            for (int k = 0; k < 6 && !(vld(ws) && mcnt[ws] > 0); k++) ws = pick();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, pick(), pick(), pick(),
                 $urandom_range(0, 2) != 0, ws, $urandom);
        end

        @(negedge clk);
        #1;
        cmp("queue_drained", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
